// File: rtl/mmio_uart.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mmio_uart: memory-mapped 8N1 UART with TX/RX byte FIFOs and RX interrupt
// Revision: 1.0
// ----------------------------------------------------------------------------
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0020,
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic       hit, wr, rd;
  logic [1:0] sel;
  assign hit = (Address[31:4] == BASE_ADDR[31:4]);
  assign sel = Address[3:2];
  assign wr  = hit & MemWrite;
  assign rd  = hit & MemRead & ~MemWrite;

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], Write_data[31:8], Write_data[4]};

  logic [2:0] ctrl;
  logic       rx_overrun, frame_err;

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_push, tx_pop, tx_full, tx_empty;

  assign tx_full  = (tx_cnt == FIFO_FULL);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr && (sel == 2'd0) && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= Write_data[7:0];
  end

  // TX FSM
  state_t        tx_state;
  logic [BW-1:0] tx_bcnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_bcnt == BIT_LAST);
  // A new frame may start from IDLE or straight out of the last STOP cycle.
  assign tx_pop = ctrl[0] && !tx_empty &&
                  ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_bit_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_bcnt  <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_bcnt <= '0;
          if (tx_pop) begin
            tx_state <= S_START;
            tx_shift <= tx_mem[tx_rp];
            uart_tx  <= 1'b0;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_state <= S_DATA;
            tx_bcnt  <= '0;
            tx_idx   <= '0;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_bcnt <= tx_bcnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_bcnt <= '0;
            if (tx_idx == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_bcnt <= tx_bcnt + 1'b1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_bcnt <= '0;
            if (tx_pop) begin
              tx_state <= S_START;
              tx_shift <= tx_mem[tx_rp];
              uart_tx  <= 1'b0;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_bcnt <= tx_bcnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RX synchronizer
  logic rx_s1, rx_line;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_line <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_line <= rx_s1;
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic          rx_stop_end, ovr_set, ferr_set;
  logic [7:0]    rx_shift;

  assign rx_full     = (rx_cnt == FIFO_FULL);
  assign rx_empty    = (rx_cnt == '0);
  assign rx_pop      = rd && (sel == 2'd1) && !rx_empty;
  assign rx_push     = rx_stop_end && rx_line && (!rx_full || rx_pop);
  assign ovr_set     = rx_stop_end && rx_line && rx_full && !rx_pop;
  assign ferr_set    = rx_stop_end && !rx_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  // RX FSM: timing is referenced to the mid-point of the start bit
  state_t        rx_state;
  logic [BW-1:0] rx_bcnt;
  logic [2:0]    rx_idx;

  assign rx_stop_end = ctrl[1] && (rx_state == S_STOP) && (rx_bcnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_bcnt  <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if (!ctrl[1]) begin
      rx_state <= S_IDLE;
      rx_bcnt  <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_bcnt <= '0;
          if (!rx_line) rx_state <= S_START;
        end
        S_START: begin
          if (rx_bcnt == HALF_LAST) begin
            rx_bcnt  <= '0;
            rx_idx   <= '0;
            rx_state <= rx_line ? S_IDLE : S_DATA;
          end else begin
            rx_bcnt <= rx_bcnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_bcnt == BIT_LAST) begin
            rx_bcnt  <= '0;
            rx_shift <= {rx_line, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else                rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_bcnt <= rx_bcnt + 1'b1;
          end
        end
        default: begin
          if (rx_bcnt == BIT_LAST) begin
            rx_bcnt  <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_bcnt <= rx_bcnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Register read mux
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (sel)
      2'd1:    rdata[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rp];
      2'd2:    rdata[5:0] = {frame_err, tx_empty, rx_overrun, !rx_empty,
                             (tx_state != S_IDLE), tx_full};
      2'd3:    rdata[2:0] = ctrl;
      default: rdata      = '0;
    endcase
  end

  // Control, sticky flags, read data and interrupt; a new error wins over a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl       <= 3'b011;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      irq        <= 1'b0;
      Read_data  <= '0;
    end else begin
      if (wr && sel == 2'd3) ctrl <= Write_data[2:0];
      if (ovr_set)                                      rx_overrun <= 1'b1;
      else if (wr && sel == 2'd2 && Write_data[3])      rx_overrun <= 1'b0;
      if (ferr_set)                                     frame_err  <= 1'b1;
      else if (wr && sel == 2'd2 && Write_data[5])      frame_err  <= 1'b0;
      irq       <= ctrl[2] & !rx_empty;
      Read_data <= rd ? rdata : 32'h0;
    end
  end

endmodule
`default_nettype wire
